// File: rtl/x2_eval_pkg.sv
// Shared definitions for the x2 approximate-synthesis QoR monitors.
//   state_t  : run-control FSM encoding (IDLE, RUN, DONE)
//   *_DEF    : default widths and run length for the x2 block
//   sat_add  : saturating add, generic up to 32-bit operands
package x2_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OUT_W_DEF   = 7;
    localparam int SAMPLES_DEF = 1024;
    localparam int CNT_W_DEF   = 11;
    localparam int ACC_W_DEF   = 14;
    localparam int HAM_W_DEF   = 3;

    // Returns a + b clamped to lim. Callers pass the all-ones value of the
    // destination width as lim and truncate the result back to that width.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim})
            return lim;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/x2_popcount.sv
// Combinational population count, shared by the QoR monitors.
//   vec : input vector (OUT_W bits)
//   cnt : number of set bits in vec (HAM_W bits)
module x2_popcount
    import x2_eval_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int HAM_W = HAM_W_DEF
) (
    input  logic [OUT_W-1:0] vec,
    output logic [HAM_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < OUT_W; i++)
            cnt = cnt + HAM_W'(vec[i]);
    end

endmodule

// File: rtl/x2_err_monitor.sv
// Output-side error monitor for the x2 block. Each accepted pair of exact and
// approximate output vectors updates the run statistics used by QoR scoring.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : clear statistics and begin a run (IDLE/DONE only)
//   in_valid, in_ready     : pair handshake; transfer when both high
//   exact_out, approx_out  : reference and approximate output vectors
//   busy, done             : run in progress / run complete, results held
//   sample_cnt, err_cnt    : pairs accepted / pairs with any mismatch
//   ham_sum, ham_max       : sum and maximum of per-pair Hamming distance
//   bit_err                : per-bit mismatch counts, slice i = [i*CNT_W +: CNT_W]
module x2_err_monitor
    import x2_eval_pkg::*;
#(
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int HAM_W   = HAM_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OUT_W-1:0]       exact_out,
    input  logic [OUT_W-1:0]       approx_out,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [ACC_W-1:0]       ham_sum,
    output logic [HAM_W-1:0]       ham_max,
    output logic [OUT_W*CNT_W-1:0] bit_err
);

    localparam logic [31:0]      CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0]      ACC_MAX = 32'((64'd1 << ACC_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SAMPLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [OUT_W-1:0] diff;
    logic [HAM_W-1:0] ham;
    logic             xfer;
    logic             clr;
    logic             last;

    assign diff = exact_out ^ approx_out;

    x2_popcount #(
        .OUT_W (OUT_W),
        .HAM_W (HAM_W)
    ) u_popcount (
        .vec (diff),
        .cnt (ham)
    );

    // in_ready is a flop that mirrors state == RUN, so a transfer can only
    // happen in RUN and in_valid never reaches in_ready combinationally.
    assign xfer = in_valid & in_ready;
    // start is honoured only outside RUN; a run cannot be restarted mid-way.
    assign clr  = start && (state != RUN);
    assign last = xfer && (sample_cnt == LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == RUN);
            busy     <= (state_nx == RUN);
            done     <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ham_sum    <= '0;
            ham_max    <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ham_sum    <= '0;
            ham_max    <= '0;
        end else if (xfer) begin
            sample_cnt <= CNT_W'(sat_add(32'(sample_cnt), 32'd1, CNT_MAX));
            err_cnt    <= CNT_W'(sat_add(32'(err_cnt), 32'(|diff), CNT_MAX));
            ham_sum    <= ACC_W'(sat_add(32'(ham_sum), 32'(ham), ACC_MAX));
            if (ham > ham_max)
                ham_max <= ham;
        end
    end

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (clr)
                cnt <= '0;
            else if (xfer)
                cnt <= CNT_W'(sat_add(32'(cnt), 32'(diff[i]), CNT_MAX));
        end

        assign bit_err[i*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_x2_err_monitor.sv
// Directed self-checking bench for x2_err_monitor. Three instances share the
// clock and reset: run lengths 4, 8 and the default 1024.
module tb_x2_err_monitor;

    localparam int OW = 7;
    localparam int CW = 11;
    localparam int AW = 14;
    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start     [3];
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [OW-1:0] exact     [3];
    logic [OW-1:0] approx    [3];
    logic          busy      [3];
    logic          done      [3];
    logic [CW-1:0] sample_cnt[3];
    logic [CW-1:0] err_cnt   [3];
    logic [AW-1:0] ham_sum   [3];
    logic [HW-1:0] ham_max   [3];
    logic [OW*CW-1:0] bit_err[3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x2_err_monitor #(.SAMPLES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .exact_out(exact[0]), .approx_out(approx[0]),
        .busy(busy[0]), .done(done[0]), .sample_cnt(sample_cnt[0]),
        .err_cnt(err_cnt[0]), .ham_sum(ham_sum[0]), .ham_max(ham_max[0]),
        .bit_err(bit_err[0])
    );

    x2_err_monitor #(.SAMPLES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .exact_out(exact[1]), .approx_out(approx[1]),
        .busy(busy[1]), .done(done[1]), .sample_cnt(sample_cnt[1]),
        .err_cnt(err_cnt[1]), .ham_sum(ham_sum[1]), .ham_max(ham_max[1]),
        .bit_err(bit_err[1])
    );

    x2_err_monitor u_full (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .exact_out(exact[2]), .approx_out(approx[2]),
        .busy(busy[2]), .done(done[2]), .sample_cnt(sample_cnt[2]),
        .err_cnt(err_cnt[2]), .ham_sum(ham_sum[2]), .ham_max(ham_max[2]),
        .bit_err(bit_err[2])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] bit_of(input int s, input int i);
        return bit_err[s][i*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
    endtask

    // Offer one pair (approx = exact ^ d) and hold it until accepted.
    task automatic send(input int s, input logic [OW-1:0] e, input logic [OW-1:0] d);
        int n = 0;
        exact[s]    = e;
        approx[s]   = e ^ d;
        in_valid[s] = 1'b1;
        while (in_ready[s] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20)
            check("send_ready_timeout", 32'(in_ready[s]), 32'd1);
        else
            tick();
        in_valid[s] = 1'b0;
    endtask

    task automatic check_zero(input string tag, input int s);
        check({tag, "_in_ready"}, 32'(in_ready[s]), 32'd0);
        check({tag, "_busy"},     32'(busy[s]), 32'd0);
        check({tag, "_done"},     32'(done[s]), 32'd0);
        check({tag, "_sample"},   32'(sample_cnt[s]), 32'd0);
        check({tag, "_err"},      32'(err_cnt[s]), 32'd0);
        check({tag, "_ham_sum"},  32'(ham_sum[s]), 32'd0);
        check({tag, "_ham_max"},  32'(ham_max[s]), 32'd0);
        check({tag, "_bit_err"},  32'(bit_err[s] != '0), 32'd0);
    endtask

    logic [CW-1:0] exp_bits[OW];

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start[s] = 1'b0; in_valid[s] = 1'b0; exact[s] = '0; approx[s] = '0;
        end
        #2;
        for (int s = 0; s < 3; s++) check_zero("reset", s);

        // Release with valid data offered but no start: nothing is accepted.
        tick();
        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b1; exact[s] = 7'h00; approx[s] = 7'h7F;
        end
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_in_ready", 32'(in_ready[0]), 32'd0);
        check("idle_sample",   32'(sample_cnt[0]), 32'd0);
        check("idle_err",      32'(err_cnt[2]), 32'd0);
        for (int s = 0; s < 3; s++) in_valid[s] = 1'b0;

        // Exact-match run of 4.
        pulse_start(0);
        check("run_busy",  32'(busy[0]), 32'd1);
        check("run_ready", 32'(in_ready[0]), 32'd1);
        for (int k = 0; k < 4; k++) send(0, 7'h55, 7'h00);
        check("match_done",    32'(done[0]), 32'd1);
        check("match_ready",   32'(in_ready[0]), 32'd0);
        check("match_sample",  32'(sample_cnt[0]), 32'd4);
        check("match_err",     32'(err_cnt[0]), 32'd0);
        check("match_ham_sum", 32'(ham_sum[0]), 32'd0);
        check("match_ham_max", 32'(ham_max[0]), 32'd0);
        check("match_bit_err", 32'(bit_err[0] != '0), 32'd0);

        // Restart from DONE clears everything the next cycle.
        pulse_start(0);
        check("restart_busy",   32'(busy[0]), 32'd1);
        check("restart_done",   32'(done[0]), 32'd0);
        check("restart_sample", 32'(sample_cnt[0]), 32'd0);

        // Mixed errors, with an ignored start in the middle of the run.
        send(0, 7'h12, 7'h01);
        send(0, 7'h34, 7'h00);
        pulse_start(0);
        check("midstart_sample", 32'(sample_cnt[0]), 32'd2);
        check("midstart_busy",   32'(busy[0]), 32'd1);
        check("midstart_err",    32'(err_cnt[0]), 32'd1);
        send(0, 7'h56, 7'h7F);
        send(0, 7'h78, 7'h03);
        check("mixed_done",    32'(done[0]), 32'd1);
        check("mixed_sample",  32'(sample_cnt[0]), 32'd4);
        check("mixed_err",     32'(err_cnt[0]), 32'd3);
        check("mixed_ham_sum", 32'(ham_sum[0]), 32'd10);
        check("mixed_ham_max", 32'(ham_max[0]), 32'd7);
        exp_bits = '{11'd3, 11'd2, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1};
        for (int i = 0; i < OW; i++)
            check($sformatf("mixed_bit_err%0d", i), 32'(bit_of(0, i)), 32'(exp_bits[i]));

        // Run of 8 with gaps; bit 6 differs on odd pairs.
        pulse_start(1);
        for (int k = 0; k < 8; k++) begin
            repeat (k % 3) tick();
            send(1, 7'(k), (k % 2 == 1) ? 7'h40 : 7'h00);
            if (k == 6)
                check("bp_ready_before_last", 32'(in_ready[1]), 32'd1);
        end
        check("bp_ready_drop", 32'(in_ready[1]), 32'd0);
        check("bp_done",       32'(done[1]), 32'd1);
        in_valid[1] = 1'b1; exact[1] = 7'h00; approx[1] = 7'h7F;
        repeat (3) tick();
        in_valid[1] = 1'b0;
        check("bp_sample",  32'(sample_cnt[1]), 32'd8);
        check("bp_err",     32'(err_cnt[1]), 32'd4);
        check("bp_ham_sum", 32'(ham_sum[1]), 32'd4);
        check("bp_ham_max", 32'(ham_max[1]), 32'd1);
        check("bp_bit6",    32'(bit_of(1, 6)), 32'd4);
        check("bp_bit0",    32'(bit_of(1, 0)), 32'd0);

        // Full 1024-vector run; bit 5 flipped on exactly 100 vectors.
        pulse_start(2);
        for (int k = 0; k < 1024; k++) begin
            if (k == 1023)
                check("full_done_early", 32'(done[2]), 32'd0);
            send(2, 7'(k), (k % 10 == 3 && k < 1000) ? 7'h20 : 7'h00);
        end
        check("full_done",    32'(done[2]), 32'd1);
        check("full_ready",   32'(in_ready[2]), 32'd0);
        check("full_sample",  32'(sample_cnt[2]), 32'd1024);
        check("full_err",     32'(err_cnt[2]), 32'd100);
        check("full_ham_sum", 32'(ham_sum[2]), 32'd100);
        check("full_ham_max", 32'(ham_max[2]), 32'd1);
        check("full_bit5",    32'(bit_of(2, 5)), 32'd100);
        check("full_bit4",    32'(bit_of(2, 4)), 32'd0);

        // Asynchronous reset in the middle of a cycle during a run.
        pulse_start(0);
        send(0, 7'h01, 7'h03);
        send(0, 7'h02, 7'h01);
        check("prerst_sample", 32'(sample_cnt[0]), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst", 0);
        check_zero("midrst_full", 2);
        tick();
        rst_n = 1'b1;
        in_valid[0] = 1'b1;
        repeat (2) tick();
        in_valid[0] = 1'b0;
        check("postrst_busy",   32'(busy[0]), 32'd0);
        check("postrst_sample", 32'(sample_cnt[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
